// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit for a word-indexed data memory.
// Sub-word stores do a read-modify-write. Loads extract the addressed lane and extend it.
// All DMEM_* outputs are decoded from state and captured registers only.
module dmem_lsu #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] DMEM_address,
  output logic [31:0] DMEM_data_in,
  output logic        DMEM_mem_write,
  output logic        DMEM_mem_read,
  input  logic [31:0] DMEM_data_out
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      r_state, w_next;
  logic        r_write, r_signed, r_err;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wword;   // store data at accept, then the merged word after READ
  logic [31:0] r_rdata;   // extended load result, 0 for stores and faults

  logic        w_accept, w_fault;
  logic [4:0]  w_sh;
  logic [31:0] w_shift, w_ld, w_mask, w_ins, w_merge;

  assign w_accept = (r_state == IDLE) && req_valid;

  // Fault decode happens on the live request fields, only consumed at acceptance.
  assign w_fault = (req_size == 2'b11) ||
                   ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                   ({2'b00, req_addr[31:2]} >= 32'(DEPTH));

  // Lane shift: byte k sits at bits [8k+7:8k]; halfwords are 2-byte aligned.
  assign w_sh    = {r_addr[1:0], 3'b000};
  assign w_shift = DMEM_data_out >> w_sh;

  // Load extraction with sign/zero extension.
  always_comb begin
    w_ld = DMEM_data_out;
    case (r_size)
      2'b00:   w_ld = {{24{r_signed & w_shift[7]}},  w_shift[7:0]};
      2'b01:   w_ld = {{16{r_signed & w_shift[15]}}, w_shift[15:0]};
      default: w_ld = DMEM_data_out;
    endcase
  end

  // Sub-word store merge: replace only the addressed lane(s) of the read word.
  assign w_mask  = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << w_sh;
  assign w_ins   = (r_wword & ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF)) << w_sh;
  assign w_merge = (DMEM_data_out & ~w_mask) | w_ins;

  // State register; async reset drops any in-flight access immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state: faults go straight to RESP, word stores skip READ.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_fault)                             w_next = RESP;
          else if (req_write && req_size == 2'b10) w_next = WRITE;
          else                                     w_next = READ;
        end
      end
      READ:    w_next = r_write ? WRITE : RESP;
      WRITE:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request capture at acceptance; load result / merged store word at end of READ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= 2'b00;
      r_addr   <= 32'd0;
      r_wword  <= 32'd0;
      r_rdata  <= 32'd0;
    end else if (w_accept) begin
      r_write  <= req_write;
      r_signed <= req_signed;
      r_err    <= w_fault;
      r_size   <= req_size;
      r_addr   <= req_addr;
      r_wword  <= req_wdata;
      r_rdata  <= 32'd0;
    end else if (r_state == READ) begin
      if (r_write) r_wword <= w_merge;
      else         r_rdata <= w_ld;
    end
  end

  // Outputs decoded from state and captured registers only.
  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_rdata     = 32'd0;
    resp_err       = 1'b0;
    DMEM_address   = 32'd0;
    DMEM_data_in   = 32'd0;
    DMEM_mem_write = 1'b0;
    DMEM_mem_read  = 1'b0;
    case (r_state)
      IDLE: req_ready = 1'b1;
      READ: begin
        DMEM_address  = {2'b00, r_addr[31:2]};
        DMEM_mem_read = 1'b1;
      end
      WRITE: begin
        DMEM_address   = {2'b00, r_addr[31:2]};
        DMEM_data_in   = r_wword;
        DMEM_mem_write = 1'b1;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        resp_rdata = r_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Testbench for dmem_lsu: memory model plus a high-level reference of load/store semantics.
module tb_dmem_lsu;
  localparam int DEPTH = 256;

  logic        clk, rst;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] DMEM_address, DMEM_data_in, DMEM_data_out;
  logic        DMEM_mem_write, DMEM_mem_read;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int checks = 0;
  int errors = 0;

  dmem_lsu #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .DMEM_address(DMEM_address), .DMEM_data_in(DMEM_data_in),
    .DMEM_mem_write(DMEM_mem_write), .DMEM_mem_read(DMEM_mem_read),
    .DMEM_data_out(DMEM_data_out)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Memory: combinational read, write at posedge.
  assign DMEM_data_out = mem[DMEM_address[7:0]];
  always @(posedge clk) if (DMEM_mem_write) mem[DMEM_address[7:0]] <= DMEM_data_in;

  // One request, checked against the reference rules.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    logic        e_err;
    int          e_lat, e_rd, e_wr, got, rd, wr, idx, k;
    logic [31:0] old, e_rdata, e_word, lane;
    idx = int'(a / 4);
    k   = int'(a % 4);
    e_err = (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && k != 0) || (a / 4 >= DEPTH);
    old = e_err ? 32'd0 : ref_mem[idx];
    e_rdata = 0; e_word = old; e_rd = 0; e_wr = 0;
    if (e_err) e_lat = 1;
    else if (!w) begin
      e_lat = 2; e_rd = 1;
      if (sz == 2) e_rdata = old;
      else if (sz == 0) begin
        lane = (old >> (8 * k)) % 256;
        e_rdata = (sg && lane >= 128) ? lane + 32'hFFFF_FF00 : lane;
      end else begin
        lane = (old >> (8 * k)) % 65536;
        e_rdata = (sg && lane >= 32768) ? lane + 32'hFFFF_0000 : lane;
      end
    end else if (sz == 2) begin
      e_lat = 2; e_wr = 1; e_word = wd;
    end else begin
      e_lat = 3; e_rd = 1; e_wr = 1;
      if (sz == 0) e_word = (old & ~(32'hFF << (8 * k))) | ((wd % 256) << (8 * k));
      else         e_word = (old & ~(32'hFFFF << (8 * k))) | ((wd % 65536) << (8 * k));
    end

    @(negedge clk);
    req_valid = 1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_at_accept got %b exp 1", req_ready); end
    @(posedge clk); #1;
    // scramble fields after acceptance; they must be ignored
    req_valid = 0; req_write = ~w; req_size = ~sz; req_signed = ~sg; req_addr = ~a; req_wdata = ~wd;
    got = 0; rd = 0; wr = 0;
    for (int n = 1; n <= 8 && got == 0; n++) begin
      @(negedge clk);
      if (DMEM_mem_read && DMEM_mem_write) begin
        errors++; $display("FAIL rd_wr_overlap both strobes high at n=%0d", n);
      end
      if (DMEM_mem_read) rd++;
      if (DMEM_mem_write) begin
        wr++;
        checks++;
        if (DMEM_address !== 32'(idx) || DMEM_data_in !== e_word) begin
          errors++;
          $display("FAIL write_word addr %h data %h exp addr %h data %h", DMEM_address, DMEM_data_in, idx, e_word);
        end
      end
      if (resp_valid) got = n;
      else if (resp_rdata !== 0 || resp_err !== 0) begin
        errors++; $display("FAIL idle_resp rdata %h err %b exp 0 0", resp_rdata, resp_err);
      end
      if (!resp_valid && req_ready !== 1'b0) begin
        errors++; $display("FAIL busy_ready got %b exp 0 at n=%0d", req_ready, n);
      end
    end
    checks++;
    if (got != e_lat) begin errors++; $display("FAIL latency got %0d exp %0d addr %h", got, e_lat, a); end
    checks++;
    if (resp_rdata !== e_rdata || resp_err !== e_err) begin
      errors++;
      $display("FAIL resp addr %h sz %0d w %b: rdata %h err %b exp %h %b", a, sz, w, resp_rdata, resp_err, e_rdata, e_err);
    end
    checks++;
    if (rd != e_rd || wr != e_wr) begin
      errors++; $display("FAIL strobes rd %0d wr %0d exp %0d %0d", rd, wr, e_rd, e_wr);
    end
    if (w && !e_err) begin
      ref_mem[idx] = e_word;
      @(negedge clk);
      checks++;
      if (mem[idx] !== ref_mem[idx]) begin
        errors++; $display("FAIL mem_after_store got %h exp %h", mem[idx], ref_mem[idx]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; req_valid = 0; req_write = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
    #12;
    checks++;
    if (req_ready !== 1 || resp_valid !== 0 || resp_rdata !== 0 || resp_err !== 0 ||
        DMEM_address !== 0 || DMEM_data_in !== 0 || DMEM_mem_write !== 0 || DMEM_mem_read !== 0) begin
      errors++;
      $display("FAIL reset_outputs ready %b rv %b rd %h err %b addr %h din %h wr %b rd %b exp 1 0 0 0 0 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err, DMEM_address, DMEM_data_in, DMEM_mem_write, DMEM_mem_read);
    end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_directed();
    mem[3] = 32'h8899AABB; ref_mem[3] = 32'h8899AABB;
    do_req(0, 2'd2, 0, 32'h0C, 0);           // word load
    do_req(0, 2'd0, 1, 32'h0D, 0);           // byte signed -> FFFFFFAA
    do_req(0, 2'd0, 0, 32'h0D, 0);           // byte unsigned -> AA
    do_req(0, 2'd1, 1, 32'h0E, 0);           // half signed -> FFFF8899
    do_req(1, 2'd0, 0, 32'h0E, 32'h11);      // byte store -> 8811AABB
    checks++;
    if (mem[3] !== 32'h8811AABB) begin errors++; $display("FAIL byte_store_const got %h exp 8811aabb", mem[3]); end
    do_req(0, 2'd2, 0, 32'h0E, 0);           // misaligned word -> err
    do_req(1, 2'd1, 0, 32'h400, 32'h1234);   // out of range -> err
    do_req(0, 2'd3, 0, 32'h10, 0);           // illegal size
    do_req(1, 2'd2, 0, 32'h3FC, 32'hDEADBEEF); // last word
  endtask

  task automatic test_reset_in_write();
    @(negedge clk);
    req_valid = 1; req_write = 1; req_size = 1; req_signed = 0; req_addr = 32'h20; req_wdata = 32'hCAFE;
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (DMEM_mem_write !== 1'b1) begin errors++; $display("FAIL rmw_write_phase got %b exp 1", DMEM_mem_write); end
    #1 rst = 1; #1;
    checks++;
    if (DMEM_mem_write !== 0 || req_ready !== 1) begin
      errors++; $display("FAIL async_abort wr %b ready %b exp 0 1", DMEM_mem_write, req_ready);
    end
    @(posedge clk); @(negedge clk); rst = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 0 || req_ready !== 1) begin
        errors++; $display("FAIL post_abort rv %b ready %b exp 0 1", resp_valid, req_ready);
      end
    end
    checks++;
    if (mem[8] !== ref_mem[8]) begin errors++; $display("FAIL abort_mem got %h exp %h", mem[8], ref_mem[8]); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_rdy, exp_rv;
    exp_rdy = 5'b00100; exp_rv = 5'b10010;  // bit n-1 is cycle n after first accept
    @(negedge clk);
    req_valid = 1; req_write = 0; req_size = 2; req_signed = 0; req_addr = 32'h40; req_wdata = 0;
    @(posedge clk);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== exp_rdy[n-1] || resp_valid !== exp_rv[n-1]) begin
        errors++;
        $display("FAIL b2b cycle %0d ready %b rv %b exp %b %b", n, req_ready, resp_valid, exp_rdy[n-1], exp_rv[n-1]);
      end
    end
    req_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 200; i++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 + 15));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    test_reset();
    test_directed();
    test_reset_in_write();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
